// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port among NUM_REQ requesters.
// One transaction in flight at a time; each one takes MEM_LAT strobe cycles
// followed by a single-cycle ack, then a mandatory IDLE cycle.
module dmem_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int AW      = 8,
  parameter int DW      = 16,
  parameter int MEM_LAT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    we,
  input  logic [NUM_REQ*AW-1:0] addr,
  input  logic [NUM_REQ*DW-1:0] wdata,
  output logic [NUM_REQ-1:0]    ack,
  output logic [NUM_REQ-1:0]    grant,
  output logic [DW-1:0]         rdata,
  output logic                  busy,
  output logic [AW-1:0]         mem_addr,
  output logic [DW-1:0]         mem_wdata,
  output logic                  mem_rd,
  output logic                  mem_wr,
  input  logic [DW-1:0]         mem_rdata
);

  localparam int LW = $clog2(NUM_REQ);
  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 1);
  localparam logic [LW-1:0] LAST_RST = LW'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t state, state_nxt;
  logic [NUM_REQ-1:0] grant_nxt, ack_nxt;
  logic [DW-1:0]      rdata_nxt, mem_wdata_nxt;
  logic [AW-1:0]      mem_addr_nxt;
  logic               mem_rd_nxt, mem_wr_nxt;
  logic [CW-1:0]      cnt, cnt_nxt;
  logic [LW-1:0]      last, last_nxt;

  logic               pick_valid;
  logic [LW-1:0]      pick, pidx;
  logic               sel_we;
  logic [AW-1:0]      sel_addr;
  logic [DW-1:0]      sel_wdata;

  assign busy = (state != IDLE);

  // Round-robin scan starting just after the previous winner; scanning the
  // offsets backwards lets the nearest asserted requester overwrite the rest.
  always_comb begin
    pick_valid = 1'b0;
    pick       = '0;
    pidx       = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      pidx = LW'((int'(last) + k) % NUM_REQ);
      if (req[pidx]) begin
        pick_valid = 1'b1;
        pick       = pidx;
      end
    end
  end

  // Select the winning requester's command fields out of the flattened buses.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (LW'(i) == pick) begin
        sel_we    = we[i];
        sel_addr  = addr[i*AW +: AW];
        sel_wdata = wdata[i*DW +: DW];
      end
    end
  end

  // Next-state and next-output logic; every register holds unless changed.
  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant;
    ack_nxt       = ack;
    rdata_nxt     = rdata;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    mem_rd_nxt    = mem_rd;
    mem_wr_nxt    = mem_wr;
    cnt_nxt       = cnt;
    last_nxt      = last;
    case (state)
      IDLE: begin
        ack_nxt   = '0;
        grant_nxt = '0;
        if (pick_valid) begin
          grant_nxt     = NUM_REQ'(1) << pick;
          last_nxt      = pick;
          mem_addr_nxt  = sel_addr;
          mem_wdata_nxt = sel_wdata;
          mem_wr_nxt    = sel_we;
          mem_rd_nxt    = ~sel_we;
          cnt_nxt       = CNT_LOAD;
          state_nxt     = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt == '0) begin
          if (mem_rd) begin
            rdata_nxt = mem_rdata;
          end
          mem_rd_nxt = 1'b0;
          mem_wr_nxt = 1'b0;
          ack_nxt    = grant;
          state_nxt  = RESP;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      RESP: begin
        ack_nxt   = '0;
        grant_nxt = '0;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register; reset abandons any transaction in flight without an ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      grant     <= '0;
      ack       <= '0;
      rdata     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      cnt       <= '0;
      last      <= LAST_RST;
    end else begin
      state     <= state_nxt;
      grant     <= grant_nxt;
      ack       <= ack_nxt;
      rdata     <= rdata_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      mem_rd    <= mem_rd_nxt;
      mem_wr    <= mem_wr_nxt;
      cnt       <= cnt_nxt;
      last      <= last_nxt;
    end
  end

endmodule
